// File: rtl/if_fetch_buf.sv
// ---------------------------------------------------------------------------
// if_fetch_buf -- instruction fetch stage with an in-order prefetch queue.
//
// Issues one instruction-bus request per cycle for the current pc and tells
// the PC register to hold (nop) when the request was not granted. Responses
// return in order and are written into a DEPTH-entry queue. Decode pulls
// them out with a valid/ready handshake. A jump flushes the queue, and
// responses still in flight are counted and dropped as they arrive.
//
// Optional build macro: IF_FETCH_ERR_EN adds per-entry bus error tracking.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   pc, jump           fetch address / redirect (PC loads target same cycle)
//   nop                1 = pc not consumed this cycle, PC register holds
//   ibus_req/addr/gnt  request channel (addr = pc)
//   ibus_rvalid/rdata  in-order response channel
//   ibus_err, inst_err (IF_FETCH_ERR_EN only) response error / error of inst
//   inst_valid/ready   handshake to decode
//   inst, inst_addr    instruction word and its address
// ---------------------------------------------------------------------------
module if_fetch_buf #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] pc,
   input  logic        jump,
   output logic        nop,
   output logic        ibus_req,
   output logic [31:0] ibus_addr,
   input  logic        ibus_gnt,
   input  logic        ibus_rvalid,
   input  logic [31:0] ibus_rdata,
`ifdef IF_FETCH_ERR_EN
   input  logic        ibus_err,
   output logic        inst_err,
`endif
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_addr
);
   localparam int          PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = DEPTH[PW:0];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW:0]      wr, fill, rd;
   logic [PW:0]      discard;
   logic [DEPTH-1:0] filled;
   logic [31:0]      last_addr;
   logic [31:0]      addr_mem [DEPTH];
   logic [31:0]      data_mem [DEPTH];

   logic [PW-1:0]    wr_idx, fill_idx, rd_idx;
   logic [PW:0]      alloc_cnt, inflight;
   logic             grant, rsp_drop, rsp_fill, consume;
   logic [PW+1:0]    disc_sum;
   logic [PW:0]      disc_flush;

   assign wr_idx    = wr[PW-1:0];
   assign fill_idx  = fill[PW-1:0];
   assign rd_idx    = rd[PW-1:0];
   assign alloc_cnt = wr - rd;
   assign inflight  = wr - fill;

   assign ibus_req  = rstn & ~jump & (alloc_cnt < FULL);
   assign ibus_addr = pc;
   assign grant     = ibus_req & ibus_gnt;
   // Held low in reset and forced low on jump: the PC register must not see
   // jump and hold together.
   assign nop       = rstn & ~grant & ~jump;

   assign rsp_drop  = ibus_rvalid & (discard != '0);
   // A response with nothing allocated-unfilled is stray and ignored.
   assign rsp_fill  = ibus_rvalid & (discard == '0) & (fill != wr);

   assign inst_valid = filled[rd_idx] & (alloc_cnt != '0) & ~jump;
   assign consume    = inst_valid & inst_ready;
   assign inst       = inst_valid ? data_mem[rd_idx] : NOP_INST;
   assign inst_addr  = inst_valid ? addr_mem[rd_idx] : last_addr;

   // Everything still on the bus after a flush must be dropped: responses
   // already marked for discard plus the allocated-unfilled entries, less
   // the one response (if any) arriving in the jump cycle itself.
   always_comb begin
      disc_sum = {1'b0, discard} + {1'b0, inflight}
               - {{(PW+1){1'b0}}, (rsp_drop | rsp_fill)};
      if (disc_sum > {1'b0, FULL})
         disc_flush = FULL;
      else
         disc_flush = disc_sum[PW:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr        <= '0;
         fill      <= '0;
         rd        <= '0;
         discard   <= '0;
         filled    <= '0;
         last_addr <= '0;
      end else if (jump) begin
         // No grant or consume can happen in a jump cycle.
         fill    <= wr;
         rd      <= wr;
         filled  <= '0;
         discard <= disc_flush;
      end else begin
         if (grant)
            wr <= wr + 1'b1;
         if (rsp_drop)
            discard <= discard - 1'b1;
         // fill and rd never index the same entry here: a filled entry at rd
         // implies fill is ahead of rd by less than DEPTH.
         if (rsp_fill) begin
            filled[fill_idx] <= 1'b1;
            fill             <= fill + 1'b1;
         end
         if (consume) begin
            filled[rd_idx] <= 1'b0;
            rd             <= rd + 1'b1;
         end
         if (inst_valid)
            last_addr <= addr_mem[rd_idx];
      end
   end

   // Payload storage needs no reset; validity is tracked by filled.
   always_ff @(posedge clk) begin
      if (grant)
         addr_mem[wr_idx] <= pc;
      if (rsp_fill)
         data_mem[fill_idx] <= ibus_rdata;
   end

`ifdef IF_FETCH_ERR_EN
   logic [DEPTH-1:0] err_mem;

   always_ff @(posedge clk) begin
      if (rsp_fill)
         err_mem[fill_idx] <= ibus_err;
   end

   assign inst_err = inst_valid & err_mem[rd_idx];
`endif

endmodule

// File: tb/tb_if_fetch_buf.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_buf -- directed self-checking bench for if_fetch_buf.
// A small PC register model follows nop/jump; the instruction bus is driven
// directly by each scenario. Inputs change 1 time unit after the rising
// edge, outputs are sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_if_fetch_buf;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] pc = '0;
   logic        jump = 1'b0;
   logic [31:0] jump_tgt = '0;
   logic        nop;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_gnt = 1'b0;
   logic        ibus_rvalid = 1'b0;
   logic [31:0] ibus_rdata = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_addr;
`ifdef IF_FETCH_ERR_EN
   logic        ibus_err = 1'b0;
   logic        inst_err;
`endif

   int n_vec;
   int n_err;

   if_fetch_buf #(.DEPTH(4), .NOP_INST(NOP)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .pc          (pc),
      .jump        (jump),
      .nop         (nop),
      .ibus_req    (ibus_req),
      .ibus_addr   (ibus_addr),
      .ibus_gnt    (ibus_gnt),
      .ibus_rvalid (ibus_rvalid),
      .ibus_rdata  (ibus_rdata),
`ifdef IF_FETCH_ERR_EN
      .ibus_err    (ibus_err),
      .inst_err    (inst_err),
`endif
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_addr   (inst_addr)
   );

   always #5 clk = ~clk;

   // PC register model: loads target on jump, advances when not held.
   always @(posedge clk) begin
      if (!rstn)      pc <= '0;
      else if (jump)  pc <= jump_tgt;
      else if (!nop)  pc <= pc + 32'd4;
   end

   function automatic logic [31:0] dat(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      jump = 1'b0; ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
      inst_ready = 1'b0;
`ifdef IF_FETCH_ERR_EN
      ibus_err = 1'b0;
`endif
   endtask

   task automatic do_reset;
      idle();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic test_reset;
      rstn = 1'b0; ibus_gnt = 1'b1; inst_ready = 1'b1;
      ibus_rvalid = 1'b1; ibus_rdata = 32'h1234_5678;
      tick();
      tick();
      n_vec++;
      if (ibus_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", ibus_req); end
      n_vec++;
      if (nop !== 1'b0) begin n_err++; $display("FAIL reset_nop got %b exp 0", nop); end
      n_vec++;
      if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
      n_vec++;
      if (inst !== NOP) begin n_err++; $display("FAIL reset_inst got %h exp %h", inst, NOP); end
      n_vec++;
      if (inst_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h exp 0", inst_addr); end
      idle();
   endtask

   task automatic test_stream;
      logic        prev_g;
      logic [31:0] prev_a;
      logic [31:0] ea;
      do_reset();
      prev_g = 1'b0; prev_a = '0;
      inst_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         ibus_gnt = 1'b1; ibus_rvalid = prev_g; ibus_rdata = dat(prev_a);
         #1;
         n_vec++;
         if (ibus_req !== 1'b1 || nop !== 1'b0 || ibus_addr !== 32'(4 * c)) begin
            n_err++;
            $display("FAIL stream_bus c=%0d got req=%b nop=%b addr=%h exp req=1 nop=0 addr=%h",
                     c, ibus_req, nop, ibus_addr, 32'(4 * c));
         end
         ea = (c >= 2) ? 32'(4 * (c - 2)) : 32'h0;
         n_vec++;
         if (inst_valid !== (c >= 2) || (c >= 2 && (inst !== dat(ea) || inst_addr !== ea))) begin
            n_err++;
            $display("FAIL stream_inst c=%0d got v=%b inst=%h addr=%h exp v=%b addr=%h",
                     c, inst_valid, inst, inst_addr, (c >= 2), ea);
         end
         if (inst_valid && inst_ready) $display("  stream c%0d decode <- %h @ %h", c, inst, inst_addr);
         prev_g = 1'b1; prev_a = 32'(4 * c);
         tick();
      end
      idle();
   endtask

   task automatic test_full;
      logic [0:12] g   = 13'b1111111110000;
      logic [0:12] rdy = 13'b0000001111111;
      logic [0:12] er  = 13'b1111000111111;
      logic [0:12] en  = 13'b0000111001111;
      logic [0:12] ev  = 13'b0011111111110;
      logic [31:0] ea  [13] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h10, 32'h10,
                                32'h10, 32'h14, 32'h18, 32'h18, 32'h18, 32'h18};
      logic [31:0] eia [13] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h14};
      logic        prev_g;
      logic [31:0] prev_a;
      logic [31:0] exp_i;
      do_reset();
      prev_g = 1'b0; prev_a = '0;
      for (int c = 0; c < 13; c++) begin
         ibus_gnt = g[c]; inst_ready = rdy[c];
         ibus_rvalid = prev_g; ibus_rdata = dat(prev_a);
         #1;
         exp_i = ev[c] ? dat(eia[c]) : NOP;
         n_vec++;
         if (ibus_req !== er[c] || nop !== en[c] || ibus_addr !== ea[c]) begin
            n_err++;
            $display("FAIL full_bus c=%0d got req=%b nop=%b addr=%h exp req=%b nop=%b addr=%h",
                     c, ibus_req, nop, ibus_addr, er[c], en[c], ea[c]);
         end
         n_vec++;
         if (inst_valid !== ev[c] || inst !== exp_i || inst_addr !== eia[c]) begin
            n_err++;
            $display("FAIL full_inst c=%0d got v=%b inst=%h addr=%h exp v=%b inst=%h addr=%h",
                     c, inst_valid, inst, inst_addr, ev[c], exp_i, eia[c]);
         end
         if (inst_valid && inst_ready) $display("  full c%0d decode <- %h @ %h", c, inst, inst_addr);
         prev_g = g[c] & er[c]; prev_a = ea[c];
         tick();
      end
      idle();
   endtask

   task automatic test_jump;
      logic [0:9]  g   = 10'b1111100000;
      logic [0:9]  j   = 10'b0001000000;
      logic [0:9]  rv  = 10'b0000011110;
      logic [0:9]  er  = 10'b1110111111;
      logic [0:9]  en  = 10'b0000011111;
      logic [0:9]  ev  = 10'b0000000001;
      logic [31:0] rdv [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEAD_0000,
                                32'hDEAD_0004, 32'hDEAD_0008, 32'hC0DE_0100, 32'h0};
      logic [31:0] ea  [10] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104,
                                32'h104, 32'h104, 32'h104, 32'h104};
      logic [31:0] eia;
      logic [31:0] exp_i;
      do_reset();
      inst_ready = 1'b1; jump_tgt = 32'h100;
      for (int c = 0; c < 10; c++) begin
         ibus_gnt = g[c]; jump = j[c]; ibus_rvalid = rv[c]; ibus_rdata = rdv[c];
         #1;
         eia   = ev[c] ? 32'h100 : 32'h0;
         exp_i = ev[c] ? 32'hC0DE_0100 : NOP;
         n_vec++;
         if (ibus_req !== er[c] || nop !== en[c] || ibus_addr !== ea[c]) begin
            n_err++;
            $display("FAIL jump_bus c=%0d got req=%b nop=%b addr=%h exp req=%b nop=%b addr=%h",
                     c, ibus_req, nop, ibus_addr, er[c], en[c], ea[c]);
         end
         n_vec++;
         if (inst_valid !== ev[c] || inst !== exp_i || inst_addr !== eia) begin
            n_err++;
            $display("FAIL jump_inst c=%0d got v=%b inst=%h addr=%h exp v=%b inst=%h addr=%h",
                     c, inst_valid, inst, inst_addr, ev[c], exp_i, eia);
         end
         if (inst_valid && inst_ready) $display("  jump c%0d decode <- %h @ %h", c, inst, inst_addr);
         tick();
      end
      idle();
   endtask

   task automatic test_jump_rvalid;
      logic [0:6]  g   = 7'b1101000;
      logic [0:6]  j   = 7'b0010000;
      logic [0:6]  rv  = 7'b0011100;
      logic [0:6]  er  = 7'b1101111;
      logic [0:6]  en  = 7'b0000111;
      logic [0:6]  ev  = 7'b0000010;
      logic [31:0] rdv [7] = '{32'h0, 32'h0, 32'hBAD0_0000, 32'hBAD0_0004,
                               32'hC0DE_0200, 32'h0, 32'h0};
      logic [31:0] ea  [7] = '{32'h0, 32'h4, 32'h8, 32'h200, 32'h204, 32'h204, 32'h204};
      logic [31:0] eia [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h200, 32'h200};
      logic [31:0] exp_i;
      do_reset();
      inst_ready = 1'b1; jump_tgt = 32'h200;
      for (int c = 0; c < 7; c++) begin
         ibus_gnt = g[c]; jump = j[c]; ibus_rvalid = rv[c]; ibus_rdata = rdv[c];
         #1;
         exp_i = ev[c] ? 32'hC0DE_0200 : NOP;
         n_vec++;
         if (ibus_req !== er[c] || nop !== en[c] || ibus_addr !== ea[c]) begin
            n_err++;
            $display("FAIL jrv_bus c=%0d got req=%b nop=%b addr=%h exp req=%b nop=%b addr=%h",
                     c, ibus_req, nop, ibus_addr, er[c], en[c], ea[c]);
         end
         n_vec++;
         if (inst_valid !== ev[c] || inst !== exp_i || inst_addr !== eia[c]) begin
            n_err++;
            $display("FAIL jrv_inst c=%0d got v=%b inst=%h addr=%h exp v=%b inst=%h addr=%h",
                     c, inst_valid, inst, inst_addr, ev[c], exp_i, eia[c]);
         end
         if (inst_valid && inst_ready) $display("  jrv c%0d decode <- %h @ %h", c, inst, inst_addr);
         tick();
      end
      idle();
   endtask

   task automatic test_gnt_toggle;
      logic [0:7]  g   = 8'b10101000;
      logic [0:7]  en  = 8'b01010111;
      logic [0:7]  ev  = 8'b00101010;
      logic [31:0] ea  [8] = '{32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'hC, 32'hC, 32'hC};
      logic [31:0] eia [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8};
      logic        prev_g;
      logic [31:0] prev_a;
      logic [31:0] exp_i;
      do_reset();
      inst_ready = 1'b1;
      prev_g = 1'b0; prev_a = '0;
      for (int c = 0; c < 8; c++) begin
         ibus_gnt = g[c]; ibus_rvalid = prev_g; ibus_rdata = dat(prev_a);
         #1;
         exp_i = ev[c] ? dat(eia[c]) : NOP;
         n_vec++;
         if (ibus_req !== 1'b1 || nop !== en[c] || ibus_addr !== ea[c]) begin
            n_err++;
            $display("FAIL toggle_bus c=%0d got req=%b nop=%b addr=%h exp req=1 nop=%b addr=%h",
                     c, ibus_req, nop, ibus_addr, en[c], ea[c]);
         end
         n_vec++;
         if (inst_valid !== ev[c] || inst !== exp_i || inst_addr !== eia[c]) begin
            n_err++;
            $display("FAIL toggle_inst c=%0d got v=%b inst=%h addr=%h exp v=%b inst=%h addr=%h",
                     c, inst_valid, inst, inst_addr, ev[c], exp_i, eia[c]);
         end
         if (inst_valid && inst_ready) $display("  toggle c%0d decode <- %h @ %h", c, inst, inst_addr);
         prev_g = g[c]; prev_a = ea[c];
         tick();
      end
      idle();
   endtask

   task automatic test_reset_mid;
      do_reset();
      ibus_gnt = 1'b1;
      tick();
      ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = dat(32'h0);
      tick();
      ibus_rvalid = 1'b0;
      #1;
      n_vec++;
      if (inst_valid !== 1'b1 || inst_addr !== 32'h0) begin
         n_err++;
         $display("FAIL rmid_pre got v=%b addr=%h exp v=1 addr=0", inst_valid, inst_addr);
      end
      rstn = 1'b0;
      #1;
      n_vec++;
      if (inst_valid !== 1'b0 || ibus_req !== 1'b0 || inst !== NOP || inst_addr !== 32'h0) begin
         n_err++;
         $display("FAIL rmid_async got v=%b req=%b inst=%h addr=%h exp v=0 req=0 inst=%h addr=0",
                  inst_valid, ibus_req, inst, inst_addr, NOP);
      end
      tick();
      rstn = 1'b1;
      // Stray response from before the reset: nothing allocated, must be ignored.
      ibus_rvalid = 1'b1; ibus_rdata = 32'hBAD0_0040;
      tick();
      ibus_rvalid = 1'b0; ibus_gnt = 1'b1;
      tick();
      ibus_gnt = 1'b0;
      #1;
      n_vec++;
      if (inst_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rmid_stray got v=%b inst=%h exp v=0", inst_valid, inst);
      end
      idle();
   endtask

`ifdef IF_FETCH_ERR_EN
   task automatic test_err;
      logic [0:8]  g   = 9'b111010000;
      logic [0:8]  j   = 9'b000001000;
      logic [0:8]  rv  = 9'b011100100;
      logic [0:8]  re  = 9'b000100100;
      logic [0:8]  ev  = 9'b001110000;
      logic [0:8]  ee  = 9'b000010000;
      logic [31:0] rdv [9] = '{32'h0, 32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008,
                               32'h0, 32'h0, 32'hBAD0_000C, 32'h0, 32'h0};
      do_reset();
      inst_ready = 1'b1; jump_tgt = 32'h300;
      for (int c = 0; c < 9; c++) begin
         ibus_gnt = g[c]; jump = j[c]; ibus_rvalid = rv[c]; ibus_rdata = rdv[c];
         ibus_err = re[c];
         #1;
         n_vec++;
         if (inst_valid !== ev[c] || inst_err !== ee[c]) begin
            n_err++;
            $display("FAIL err_inst c=%0d got v=%b err=%b addr=%h exp v=%b err=%b",
                     c, inst_valid, inst_err, inst_addr, ev[c], ee[c]);
         end
         if (inst_valid && inst_ready)
            $display("  err c%0d decode <- %h @ %h err=%b", c, inst, inst_addr, inst_err);
         tick();
      end
      idle();
   endtask
`endif

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_stream();
      test_full();
      test_jump();
      test_jump_rvalid();
      test_gnt_toggle();
      test_reset_mid();
`ifdef IF_FETCH_ERR_EN
      test_err();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
